// File: rtl/divider_pkg.sv
// Shared types and constants for the divider arbiter: state encoding, operand
// widths and the up-front classification that decides whether the divider is needed.
package divider_pkg;

    localparam int X1_W = 32;
    localparam int X2_W = 16;
    localparam int Y_W  = 16;

    localparam logic [Y_W-1:0] Y_SAT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic dbz;
        logic ovf;
    } cls_t;

    // The quotient fits in Y_W bits exactly when the dividend's upper half is below the divisor.
    function automatic cls_t classify(input logic [X2_W-1:0] x1_hi, input logic [X2_W-1:0] x2);
        cls_t c;
        c.dbz = (x2 == '0);
        c.ovf = !c.dbz && (x1_hi >= x2);
        return c;
    endfunction

endpackage

// File: rtl/divider_arbiter_if.sv
// Requester and response handshake bundle for divider_arbiter.
// master = requesters/consumer side, slave = arbiter side.
interface divider_arbiter_if #(
    parameter int N_REQ = 4
);
    import divider_pkg::*;

    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [X1_W*N_REQ-1:0] req_x1;
    logic [X2_W*N_REQ-1:0] req_x2;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [Y_W-1:0]        rsp_y;
    logic [ID_W-1:0]       rsp_id;
    logic                  rsp_dbz;
    logic                  rsp_ovf;

    modport master (
        output req_valid, req_x1, req_x2, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_id, rsp_dbz, rsp_ovf
    );

    modport slave (
        input  req_valid, req_x1, req_x2, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_id, rsp_dbz, rsp_ovf
    );

endinterface

// File: rtl/divider.sv
// Combinational unsigned 32/16 divider, truncating quotient to 16 bits.
// A zero divisor yields all-ones so the output is never undefined.
module divider
    import divider_pkg::*;
(
    input  logic [X1_W-1:0] x1,
    input  logic [X2_W-1:0] x2,
    output logic [Y_W-1:0]  y
);

    assign y = (x2 == '0) ? Y_SAT : Y_W'(x1 / X1_W'(x2));

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from a rotating pointer;
// the pointer moves to just past the winner when the grant is consumed.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic                     advance,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx
);

    localparam int ID_W = $clog2(N_REQ);

    logic [ID_W-1:0] ptr;
    logic            found;
    int              idx;

    // NOTE: every combinational output gets a default before the search loop, so no path leaves it unassigned (no latch).
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one external combinational divider among N_REQ requesters: round-robin
// grant, registered operands held for SETTLE_CYCLES, saturated fast path for dbz/ovf.
module divider_arbiter
    import divider_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    divider_arbiter_if.slave  bus,
    output logic [X1_W-1:0]   div_x1,
    output logic [X2_W-1:0]   div_x2,
    input  logic [Y_W-1:0]    div_y
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_done;

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_idx;
    logic              accept;
    logic [X1_W-1:0]   x1_sel;
    logic [X2_W-1:0]   x2_sel;
    cls_t              cls;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grant is only visible in IDLE and is held off while reset is asserted.
    assign bus.req_ready = (state == IDLE && rst) ? grant : '0;
    assign accept        = |(bus.req_valid & bus.req_ready);

    assign x1_sel   = bus.req_x1[int'(grant_idx)*X1_W +: X1_W];
    assign x2_sel   = bus.req_x2[int'(grant_idx)*X2_W +: X2_W];
    assign cls      = classify(x1_sel[X1_W-1:X1_W-X2_W], x2_sel);
    assign cnt_done = (cnt == '0);

    assign bus.rsp_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = (cls.dbz || cls.ovf) ? RESP : BUSY;
            BUSY: if (cnt_done) state_nxt = RESP;
            RESP: if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands stay latched after the response so the divider input only moves on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_x1      <= '0;
            div_x2      <= '0;
            cnt         <= '0;
            bus.rsp_y   <= '0;
            bus.rsp_id  <= '0;
            bus.rsp_dbz <= 1'b0;
            bus.rsp_ovf <= 1'b0;
        end else if (accept) begin
            div_x1      <= x1_sel;
            div_x2      <= x2_sel;
            cnt         <= CNT_W'(SETTLE_CYCLES - 1);
            bus.rsp_id  <= grant_idx;
            bus.rsp_dbz <= cls.dbz;
            bus.rsp_ovf <= cls.ovf;
            bus.rsp_y   <= (cls.dbz || cls.ovf) ? Y_SAT : '0;
        end else if (state == BUSY) begin
            if (cnt_done) begin
                bus.rsp_y <= div_y;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with the divider beside it: latency, fast
// paths, round-robin order, response back-pressure and reset mid-operation.
module tb_divider_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] div_x1;
    logic [15:0] div_x2;
    logic [15:0] div_y;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    divider_arbiter_if #(.N_REQ(4)) bus ();

    divider_arbiter #(.N_REQ(4), .SETTLE_CYCLES(3)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .div_x1 (div_x1),
        .div_x2 (div_x2),
        .div_y  (div_y)
    );

    divider u_div (
        .x1 (div_x1),
        .x2 (div_x2),
        .y  (div_y)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int id, input logic [31:0] x1, input logic [15:0] x2);
        bus.req_x1[id*32 +: 32] = x1;
        bus.req_x2[id*16 +: 16] = x2;
    endtask

    // Single requester asks; grant seen is compared, then one accept edge passes.
    task automatic issue(input int id, input logic [31:0] x1, input logic [15:0] x2,
                         input logic [3:0] exp_ready);
        @(negedge clk);
        set_ops(id, x1, x2);
        bus.req_valid     = '0;
        bus.req_valid[id] = 1'b1;
        #1;
        check("req_ready_grant", 32'(bus.req_ready), 32'(exp_ready));
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = '0;
    endtask

    // Counts edges after the accepting edge until rsp_valid; operands must not move meanwhile.
    task automatic wait_rsp(input logic [31:0] x1, input logic [15:0] x2, output int lat);
        lat = 0;
        while (!bus.rsp_valid && lat < 50) begin
            check("div_x1_hold", div_x1, x1);
            check("div_x2_hold", 32'(div_x2), 32'(x2));
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rsp_valid_after_hs", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int gid[5];
        int gcyc[5];
        int order[5];
        int ng;
        int nr;

        order = '{0, 1, 2, 3, 0};
        gid   = '{default: -1};
        gcyc  = '{default: -100};

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_x1    = '0;
        bus.req_x2    = '0;
        bus.rsp_ready = 1'b0;
        #2 rst = 1'b0;

        // Reset: everything zero, req_ready forced low even with requests pending.
        bus.req_valid = '1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_y", 32'(bus.rsp_y), 32'd0);
        check("rst_div_x1", div_x1, 32'd0);
        check("rst_div_x2", 32'(div_x2), 32'd0);
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b1;

        // Requester 0, normal path.
        issue(0, 32'd126567892, 16'd15789, 4'b0001);
        wait_rsp(32'd126567892, 16'd15789, lat);
        check("r0_latency", 32'(lat), 32'd3);
        check("r0_rsp_y", 32'(bus.rsp_y), 32'd8016);
        check("r0_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("r0_flags", {30'd0, bus.rsp_dbz, bus.rsp_ovf}, 32'd0);
        consume();

        // Requester 2, operands held through BUSY and RESP.
        issue(2, 32'd256748369, 16'd13891, 4'b0100);
        wait_rsp(32'd256748369, 16'd13891, lat);
        check("r2_latency", 32'(lat), 32'd3);
        check("r2_rsp_y", 32'(bus.rsp_y), 32'd18483);
        check("r2_rsp_id", 32'(bus.rsp_id), 32'd2);
        check("r2_div_x1_resp", div_x1, 32'd256748369);
        check("r2_div_x2_resp", 32'(div_x2), 32'd13891);
        consume();

        // Divide by zero: fast path.
        issue(3, 32'd123, 16'd0, 4'b1000);
        wait_rsp(32'd123, 16'd0, lat);
        check("dbz_latency", 32'(lat), 32'd0);
        check("dbz_flag", 32'(bus.rsp_dbz), 32'd1);
        check("dbz_ovf_clear", 32'(bus.rsp_ovf), 32'd0);
        check("dbz_rsp_y", 32'(bus.rsp_y), 32'hFFFF);
        check("dbz_rsp_id", 32'(bus.rsp_id), 32'd3);
        check("dbz_div_x2", 32'(div_x2), 32'd0);
        consume();

        // Quotient overflow: fast path.
        issue(0, 32'h0001_0000, 16'd1, 4'b0001);
        wait_rsp(32'h0001_0000, 16'd1, lat);
        check("ovf_latency", 32'(lat), 32'd0);
        check("ovf_flag", 32'(bus.rsp_ovf), 32'd1);
        check("ovf_dbz_clear", 32'(bus.rsp_dbz), 32'd0);
        check("ovf_rsp_y", 32'(bus.rsp_y), 32'hFFFF);
        check("ovf_div_x2", 32'(div_x2), 32'd1);
        check("ovf_div_x1", div_x1, 32'h0001_0000);
        consume();

        // Reset in IDLE returns the pointer to 0, then all four requesters contend.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) set_ops(i, 32'(1000 * (i + 1)), 16'd10);
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        #1;
        ng = 0;
        nr = 0;
        for (int cyc = 0; cyc < 40 && nr < 5; cyc++) begin
            if (bus.req_ready != '0 && ng < 5) begin
                gid[ng]  = $clog2(bus.req_ready);
                gcyc[ng] = cyc;
                ng++;
            end
            if (bus.rsp_valid) begin
                check("rr_rsp_id", 32'(bus.rsp_id), 32'(order[nr]));
                check("rr_rsp_y", 32'(bus.rsp_y), 32'(100 * (order[nr] + 1)));
                nr++;
                if (nr == 5) bus.req_valid = '0;
            end
            @(negedge clk);
            #1;
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        check("rr_grants_seen", 32'(ng), 32'd5);
        check("rr_rsps_seen", 32'(nr), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check("rr_order", 32'(gid[k]), 32'(order[k]));
            if (k > 0) check("rr_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd5);
        end
        check("rr_idle_after", 32'(bus.rsp_valid), 32'd0);

        // Back-pressure: response held while rsp_ready is low, then one handshake.
        issue(1, 32'd5000, 16'd7, 4'b0010);
        wait_rsp(32'd5000, 16'd7, lat);
        check("bp_latency", 32'(lat), 32'd3);
        bus.req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_y", 32'(bus.rsp_y), 32'd714);
            check("bp_rsp_id", 32'(bus.rsp_id), 32'd1);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_one_hs", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("bp_ready_ignored", 32'(bus.rsp_valid), 32'd0);

        // Reset during BUSY: operation dropped, pointer back to 0.
        issue(2, 32'd256748369, 16'd13891, 4'b0100);
        rst = 1'b0;
        bus.req_valid = 4'b0110;
        #1;
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_rsp_y", 32'(bus.rsp_y), 32'd0);
        check("mid_rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("mid_rst_div_x1", div_x1, 32'd0);
        check("mid_rst_div_x2", 32'(div_x2), 32'd0);
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("mid_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        set_ops(1, 32'd5000, 16'd7);
        bus.req_valid = 4'b0110;
        #1;
        check("post_rst_grant", 32'(bus.req_ready), 32'b0010);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(32'd5000, 16'd7, lat);
        check("post_rst_latency", 32'(lat), 32'd3);
        check("post_rst_rsp_id", 32'(bus.rsp_id), 32'd1);
        check("post_rst_rsp_y", 32'(bus.rsp_y), 32'd714);
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/divider_arbiter.md
# divider_arbiter

Shares one combinational 32/16 `divider` instance among `N_REQ` requesters. Each requester uses a valid/ready handshake. Grants go round-robin. The block holds the divider operands stable for a fixed number of settle cycles, then registers the quotient and returns it with the requester id. Divide-by-zero and quotient overflow are detected up front, bypass the divider, and return a saturated result.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `SETTLE_CYCLES`, 3: cycles operands are held on the divider before the quotient is captured; must be ≥1.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in N_REQ: per-requester request.
- `req_ready` out N_REQ: per-requester accept, one-hot or zero.
- `req_x1` in 32·N_REQ: dividends, slice i = requester i.
- `req_x2` in 16·N_REQ: divisors, slice i = requester i.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_y` out 16: quotient.
- `rsp_id` out clog2(N_REQ): requester index.
- `rsp_dbz` out 1: divisor was zero.
- `rsp_ovf` out 1: quotient does not fit in 16 bits.
- `div_x1` out 32: registered dividend to the divider.
- `div_x2` out 16: registered divisor to the divider.
- `div_y` in 16: divider quotient.

## Operation
- FSM states:
  - IDLE: `req_ready` = one-hot round-robin grant among asserted `req_valid`, else 0.
  - BUSY: operands on divider; settle counter running.
  - RESP: `rsp_valid`=1.
- Accept: `req_valid[i] & req_ready[i]` sampled at an edge.
  - On accept, latch x1/x2 into `div_x1`/`div_x2`.
  - Latch i into `rsp_id`.
  - Advance the RR pointer to i+1 (mod N_REQ).
- Classification at accept:
  - x2==0: `rsp_dbz`=1, `rsp_y`=16'hFFFF; go to RESP.
  - Else if x1[31:16] ≥ x2: `rsp_ovf`=1, `rsp_y`=16'hFFFF; go to RESP.
  - Else: go to BUSY with counter=SETTLE_CYCLES-1; flags cleared.
- BUSY: decrement the counter each edge. At the edge where the counter==0, capture `div_y` into `rsp_y` and go to RESP.
- RESP: hold all rsp_* stable. On `rsp_valid & rsp_ready` go to IDLE.
- `req_ready`=0 outside IDLE; no accept is possible in the same cycle as the response handshake.
- `div_x1`/`div_x2` hold their last value in IDLE.
- Quotient is unsigned, truncating, no remainder.

## Timing
- Reset values (async, `rst`=0): state IDLE, RR pointer 0, counter 0; all outputs 0, including `div_x1`, `div_x2`, `rsp_y`, `rsp_id`, flags, `rsp_valid` and `req_ready` (forced 0 while in reset).
- Normal path: accept at edge T → `rsp_valid` high after edge T+SETTLE_CYCLES (T+3 at default).
- Fast path (dbz/ovf): `rsp_valid` high after edge T.
- Peak throughput: one operation per SETTLE_CYCLES+2 cycles (one IDLE bubble).
- `req_ready` is combinational from state, pointer and `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- Reset asserted mid-BUSY/RESP: the operation is dropped, no response; after release the block is in IDLE with pointer 0.
- `rsp_ready` asserted while not `rsp_valid`: ignored.

## Structure
- Package `divider_pkg`:
  - State enum (IDLE, BUSY, RESP).
  - Width constants X1_W=32, X2_W=16, Y_W=16.
  - Saturation constant Y_SAT=16'hFFFF.
- Sub-module `rr_arbiter`: parameterised N_REQ, with `req`, `advance`, `grant` one-hot, `grant_idx`. Pointer register uses the same `clk`/`rst`.
- `divider` is instantiated beside this block (not inside it) and wired through the div_* ports. The bench instantiates both.

## Test plan
- Requester 0: x1=126567892, x2=15789 → `rsp_y`=8016, id=0, flags 0, `rsp_valid` rises 3 cycles after accept.
- Requester 2: x1=256748369, x2=13891 → `rsp_y`=18483, id=2; `div_x1`/`div_x2` stable through BUSY and RESP.
- x2=0 → `rsp_dbz`=1, `rsp_y`=FFFF, 1-cycle latency. x1=32'h0001_0000, x2=1 → `rsp_ovf`=1, `rsp_y`=FFFF. In both cases `div_x2` is still loaded.
- All four `req_valid` held high with `rsp_ready`=1 → grants in order 0,1,2,3,0, each 5 cycles apart.
- `rsp_ready`=0 for 5 cycles in RESP → rsp_* constant, `req_ready` all 0, then exactly one handshake.
- `rst` pulsed low during BUSY → all outputs 0 immediately, no response emitted; the next request from requester 1 is granted first.
